// File: rtl/ahb_slave_port_mux_if.sv
// ahb_slave_port_mux_if: master-side and slave-side bus bundle around one slave port mux
interface ahb_slave_port_mux_if #(
    parameter int MASTER_NUM = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [MASTER_NUM-1:0] hgrant, hreq_m, hwrite_m, hready_m, hresp_m;
    logic [MASTER_NUM-1:0][ADDR_W-1:0] haddr_m;
    logic [MASTER_NUM-1:0][1:0] htrans_m;
    logic [MASTER_NUM-1:0][2:0] hsize_m, hburst_m;
    logic [MASTER_NUM-1:0][DATA_W-1:0] hwdata_m;
    logic [ADDR_W-1:0] haddr_s;
    logic [1:0] htrans_s;
    logic hwrite_s, hreadyout_s, hresp_s, hwait, grant_err;
    logic [2:0] hsize_s, hburst_s;
    logic [DATA_W-1:0] hwdata_s, hrdata_s, hrdata_m;
    modport slave (
        input hgrant, hreq_m, haddr_m, htrans_m, hwrite_m, hsize_m, hburst_m, hwdata_m,
        input hreadyout_s, hresp_s, hrdata_s,
        output haddr_s, htrans_s, hwrite_s, hsize_s, hburst_s, hwdata_s,
        output hready_m, hresp_m, hrdata_m, hwait, grant_err
    );
    modport master (
        output hgrant, hreq_m, haddr_m, htrans_m, hwrite_m, hsize_m, hburst_m, hwdata_m,
        output hreadyout_s, hresp_s, hrdata_s,
        input haddr_s, htrans_s, hwrite_s, hsize_s, hburst_s, hwdata_s,
        input hready_m, hresp_m, hrdata_m, hwait, grant_err
    );
endinterface

// File: rtl/ahb_slave_port_mux.sv
// ahb_slave_port_mux: per-slave address mux and data-phase owner tracking; AHB_SLAVE_PORT_MUX_ERR_EN adds two-cycle ERROR handling
module ahb_slave_port_mux #(
    parameter int MASTER_NUM = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic hclk,
    input logic hreset_n,
    ahb_slave_port_mux_if.slave bus
);
    localparam int IW = MASTER_NUM > 1 ? $clog2(MASTER_NUM) : 1;
`ifdef AHB_SLAVE_PORT_MUX_ERR_EN
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;
`else
    typedef enum logic {S_IDLE, S_DATA} state_t;
`endif
    state_t state_q, state_d;
    logic [MASTER_NUM-1:0] own_q, own_d, gsel;
    logic own_wr_q, own_wr_d, grant_err_q, grant_err_d;
    logic [IW-1:0] gi, oi;
    logic any_g, err_st, upd, act;
    always_comb begin
        gi = '0;
        oi = '0;
        for (int i = MASTER_NUM - 1; i >= 0; i--) begin
            if (bus.hgrant[i]) gi = IW'(i);
            if (own_q[i]) oi = IW'(i);
        end
    end
    assign any_g = |bus.hgrant;
    assign gsel = any_g ? MASTER_NUM'(1) << gi : '0;
`ifdef AHB_SLAVE_PORT_MUX_ERR_EN
    // owner is frozen through ERR1 so it still sees the response in ERR2
    assign err_st = state_q == S_ERR1 || state_q == S_ERR2;
    assign upd = bus.hreadyout_s && state_q != S_ERR1;
`else
    assign err_st = 1'b0;
    assign upd = bus.hreadyout_s;
`endif
    assign bus.htrans_s = (any_g && !err_st) ? bus.htrans_m[gi] : 2'b00;
    assign bus.haddr_s = any_g ? bus.haddr_m[gi] : '0;
    assign bus.hwrite_s = any_g ? bus.hwrite_m[gi] : 1'b0;
    assign bus.hsize_s = any_g ? bus.hsize_m[gi] : 3'b000;
    assign bus.hburst_s = any_g ? bus.hburst_m[gi] : 3'b000;
    assign act = bus.htrans_s[1];
    assign bus.hwait = ~bus.hreadyout_s;
    assign bus.hwdata_s = (|own_q && own_wr_q) ? bus.hwdata_m[oi] : '0;
    assign bus.hrdata_m = bus.hrdata_s;
    assign bus.hready_m = ((own_q | bus.hgrant) & {MASTER_NUM{bus.hreadyout_s}}) |
                          (~(own_q | bus.hgrant) & ~bus.hreq_m);
    assign bus.hresp_m = own_q & {MASTER_NUM{bus.hresp_s | err_st}};
    assign bus.grant_err = grant_err_q;
    always_comb begin
        own_d = upd ? (act ? gsel : '0) : own_q;
        own_wr_d = upd ? bus.hwrite_s : own_wr_q;
        grant_err_d = |(bus.hgrant & (bus.hgrant - MASTER_NUM'(1)));
`ifdef AHB_SLAVE_PORT_MUX_ERR_EN
        state_d = state_q == S_ERR2 ? S_IDLE :
                  state_q == S_ERR1 ? (bus.hreadyout_s ? S_ERR2 : S_ERR1) :
                  (state_q == S_DATA && bus.hresp_s && !bus.hreadyout_s) ? S_ERR1 :
                  bus.hreadyout_s ? (act ? S_DATA : S_IDLE) : state_q;
`else
        state_d = bus.hreadyout_s ? (act ? S_DATA : S_IDLE) : state_q;
`endif
    end
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q <= S_IDLE;
            own_q <= '0;
            own_wr_q <= 1'b0;
            grant_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            own_q <= own_d;
            own_wr_q <= own_wr_d;
            grant_err_q <= grant_err_d;
        end
    end
endmodule

// File: tb/tb_ahb_slave_port_mux.sv
// tb_ahb_slave_port_mux: directed vectors for the slave port mux (default build, ERR_EN scenario when defined)
module tb_ahb_slave_port_mux;
    logic hclk, hreset_n;
    int vec = 0;
    int errs = 0;
    ahb_slave_port_mux_if #(.MASTER_NUM(2), .ADDR_W(32), .DATA_W(32)) bus ();
    ahb_slave_port_mux #(.MASTER_NUM(2), .ADDR_W(32), .DATA_W(32)) dut (
        .hclk(hclk), .hreset_n(hreset_n), .bus(bus.slave)
    );
    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic idle_bus();
        bus.hgrant = '0; bus.hreq_m = '0; bus.hwrite_m = '0;
        bus.haddr_m = '0; bus.htrans_m = '0; bus.hsize_m = '0;
        bus.hburst_m = '0; bus.hwdata_m = '0;
        bus.hreadyout_s = 1'b1; bus.hresp_s = 1'b0; bus.hrdata_s = '0;
    endtask

    task automatic test_reset();
        idle_bus();
        hreset_n = 1'b0;
        #2;
        vec++; if (bus.htrans_s !== 2'b00) begin errs++; $display("FAIL reset_htrans got %b want 00", bus.htrans_s); end
        vec++; if (bus.hready_m !== 2'b11) begin errs++; $display("FAIL reset_hready got %b want 11", bus.hready_m); end
        vec++; if (bus.hwdata_s !== 32'h0) begin errs++; $display("FAIL reset_hwdata got %h want 0", bus.hwdata_s); end
        vec++; if (bus.grant_err !== 1'b0) begin errs++; $display("FAIL reset_grant_err got %b want 0", bus.grant_err); end
        @(negedge hclk);
        hreset_n = 1'b1;
    endtask

    task automatic test_single_write();
        tick();
        bus.hgrant = 2'b10; bus.hreq_m = 2'b10; bus.htrans_m[1] = 2'b10;
        bus.haddr_m[1] = 32'h1000; bus.hwrite_m[1] = 1'b1; bus.hsize_m[1] = 3'b010;
        #1;
        vec++; if (bus.haddr_s !== 32'h1000) begin errs++; $display("FAIL wr_haddr got %h want 1000", bus.haddr_s); end
        vec++; if (bus.htrans_s !== 2'b10 || bus.hwrite_s !== 1'b1 || bus.hsize_s !== 3'b010) begin errs++; $display("FAIL wr_ctrl got %b/%b/%b want 10/1/010", bus.htrans_s, bus.hwrite_s, bus.hsize_s); end
        vec++; if (bus.hwdata_s !== 32'h0) begin errs++; $display("FAIL wr_hwdata_addr got %h want 0", bus.hwdata_s); end
        tick();
        bus.hgrant = 2'b00; bus.hreq_m = 2'b00; bus.htrans_m[1] = 2'b00; bus.hwdata_m[1] = 32'hDEADBEEF;
        #1;
        vec++; if (bus.hwdata_s !== 32'hDEADBEEF) begin errs++; $display("FAIL wr_hwdata got %h want deadbeef", bus.hwdata_s); end
        vec++; if (bus.htrans_s !== 2'b00 || bus.haddr_s !== 32'h0) begin errs++; $display("FAIL wr_nogrant got %b/%h want 00/0", bus.htrans_s, bus.haddr_s); end
        tick();
        #1;
        vec++; if (bus.hwdata_s !== 32'h0) begin errs++; $display("FAIL wr_hwdata_done got %h want 0", bus.hwdata_s); end
        idle_bus();
    endtask

    task automatic test_wait_states();
        tick();
        bus.hgrant = 2'b01; bus.hreq_m = 2'b01; bus.htrans_m[0] = 2'b10;
        bus.haddr_m[0] = 32'h2000; bus.hwrite_m[0] = 1'b0;
        tick();
        bus.hgrant = 2'b00; bus.hreq_m = 2'b00; bus.htrans_m[0] = 2'b00; bus.hreadyout_s = 1'b0;
        #1;
        vec++; if (bus.hwait !== 1'b1 || bus.hready_m[0] !== 1'b0) begin errs++; $display("FAIL wait1 hwait/hready0 got %b/%b want 1/0", bus.hwait, bus.hready_m[0]); end
        tick();
        #1;
        vec++; if (bus.hwait !== 1'b1 || bus.hready_m[0] !== 1'b0) begin errs++; $display("FAIL wait2 hwait/hready0 got %b/%b want 1/0", bus.hwait, bus.hready_m[0]); end
        vec++; if (bus.hready_m[1] !== 1'b1) begin errs++; $display("FAIL wait_other got %b want 1", bus.hready_m[1]); end
        tick();
        bus.hreadyout_s = 1'b1; bus.hrdata_s = 32'hCAFEF00D;
        #1;
        vec++; if (bus.hwait !== 1'b0 || bus.hready_m[0] !== 1'b1 || bus.hrdata_m !== 32'hCAFEF00D) begin errs++; $display("FAIL wait_done got %b/%b/%h want 0/1/cafef00d", bus.hwait, bus.hready_m[0], bus.hrdata_m); end
        vec++; if (bus.hwdata_s !== 32'h0) begin errs++; $display("FAIL wait_rd_hwdata got %h want 0", bus.hwdata_s); end
        idle_bus();
    endtask

    task automatic test_handover();
        tick();
        bus.hgrant = 2'b01; bus.hreq_m = 2'b11;
        bus.htrans_m[0] = 2'b10; bus.hwrite_m[0] = 1'b1; bus.haddr_m[0] = 32'h3000;
        bus.htrans_m[1] = 2'b10; bus.hwrite_m[1] = 1'b1; bus.haddr_m[1] = 32'h4000;
        tick();
        bus.hgrant = 2'b10; bus.hreq_m = 2'b10; bus.htrans_m[0] = 2'b00;
        bus.hwdata_m[0] = 32'h11111111; bus.hwdata_m[1] = 32'h22222222; bus.hresp_s = 1'b1;
        #1;
        vec++; if (bus.haddr_s !== 32'h4000) begin errs++; $display("FAIL ho_haddr got %h want 4000", bus.haddr_s); end
        vec++; if (bus.hwdata_s !== 32'h11111111) begin errs++; $display("FAIL ho_hwdata_a got %h want 11111111", bus.hwdata_s); end
        vec++; if (bus.hresp_m !== 2'b01) begin errs++; $display("FAIL ho_hresp got %b want 01", bus.hresp_m); end
        tick();
        bus.hgrant = 2'b00; bus.hreq_m = 2'b00; bus.htrans_m[1] = 2'b00; bus.hresp_s = 1'b0;
        #1;
        vec++; if (bus.hwdata_s !== 32'h22222222) begin errs++; $display("FAIL ho_hwdata_b got %h want 22222222", bus.hwdata_s); end
        bus.hresp_s = 1'b1;
        #1;
        vec++; if (bus.hresp_m !== 2'b10) begin errs++; $display("FAIL ho_hresp_b got %b want 10", bus.hresp_m); end
        idle_bus();
        tick();
    endtask

    task automatic test_held_off();
        bus.hreq_m = 2'b11; bus.hgrant = 2'b01; bus.htrans_m[0] = 2'b10; bus.htrans_m[1] = 2'b10;
        #1;
        vec++; if (bus.hready_m !== 2'b01) begin errs++; $display("FAIL held_first got %b want 01", bus.hready_m); end
        tick();
        #1;
        vec++; if (bus.hready_m !== 2'b01) begin errs++; $display("FAIL held_second got %b want 01", bus.hready_m); end
        bus.hgrant = 2'b10;
        #1;
        vec++; if (bus.hready_m !== 2'b11) begin errs++; $display("FAIL held_granted got %b want 11", bus.hready_m); end
        idle_bus();
        tick();
        tick();
    endtask

    task automatic test_bad_grant();
        bus.hgrant = 2'b11; bus.hreq_m = 2'b11; bus.htrans_m[0] = 2'b10; bus.htrans_m[1] = 2'b11;
        bus.haddr_m[0] = 32'h5000; bus.haddr_m[1] = 32'h6000; bus.hburst_m[0] = 3'b001; bus.hburst_m[1] = 3'b101;
        #1;
        vec++; if (bus.haddr_s !== 32'h5000 || bus.htrans_s !== 2'b10 || bus.hburst_s !== 3'b001) begin errs++; $display("FAIL bad_addr got %h/%b/%b want 5000/10/001", bus.haddr_s, bus.htrans_s, bus.hburst_s); end
        vec++; if (bus.grant_err !== 1'b0) begin errs++; $display("FAIL bad_err_before got %b want 0", bus.grant_err); end
        tick();
        idle_bus();
        #1;
        vec++; if (bus.grant_err !== 1'b1) begin errs++; $display("FAIL bad_err_pulse got %b want 1", bus.grant_err); end
        tick();
        #1;
        vec++; if (bus.grant_err !== 1'b0) begin errs++; $display("FAIL bad_err_after got %b want 0", bus.grant_err); end
    endtask

    task automatic test_reset_mid();
        tick();
        bus.hgrant = 2'b10; bus.hreq_m = 2'b10; bus.htrans_m[1] = 2'b10; bus.hwrite_m[1] = 1'b1;
        tick();
        idle_bus();
        bus.hwdata_m[1] = 32'hA5A5A5A5;
        #1;
        vec++; if (bus.hwdata_s !== 32'hA5A5A5A5) begin errs++; $display("FAIL rmid_pending got %h want a5a5a5a5", bus.hwdata_s); end
        hreset_n = 1'b0;
        #1;
        hreset_n = 1'b1;
        bus.hresp_s = 1'b1;
        #1;
        vec++; if (bus.hwdata_s !== 32'h0 || bus.hresp_m !== 2'b00) begin errs++; $display("FAIL rmid_discard got %h/%b want 0/00", bus.hwdata_s, bus.hresp_m); end
        idle_bus();
    endtask

`ifdef AHB_SLAVE_PORT_MUX_ERR_EN
    task automatic test_err();
        tick();
        bus.hgrant = 2'b01; bus.hreq_m = 2'b01; bus.htrans_m[0] = 2'b10;
        bus.hburst_m[0] = 3'b011; bus.haddr_m[0] = 32'h7000;
        tick();
        bus.htrans_m[0] = 2'b11; bus.haddr_m[0] = 32'h7004;
        tick();
        bus.haddr_m[0] = 32'h7008; bus.hreadyout_s = 1'b0; bus.hresp_s = 1'b1;
        #1;
        vec++; if (bus.htrans_s !== 2'b11 || bus.hresp_m !== 2'b01) begin errs++; $display("FAIL err_first got %b/%b want 11/01", bus.htrans_s, bus.hresp_m); end
        tick();
        bus.hreadyout_s = 1'b1;
        #1;
        vec++; if (bus.htrans_s !== 2'b00 || bus.hresp_m !== 2'b01) begin errs++; $display("FAIL err_err1 got %b/%b want 00/01", bus.htrans_s, bus.hresp_m); end
        tick();
        bus.hresp_s = 1'b0;
        #1;
        vec++; if (bus.htrans_s !== 2'b00 || bus.hresp_m !== 2'b01) begin errs++; $display("FAIL err_err2 got %b/%b want 00/01", bus.htrans_s, bus.hresp_m); end
        tick();
        #1;
        vec++; if (bus.htrans_s !== 2'b11 || bus.hresp_m !== 2'b00) begin errs++; $display("FAIL err_idle got %b/%b want 11/00", bus.htrans_s, bus.hresp_m); end
        idle_bus();
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_wait_states();
        test_handover();
        test_held_off();
        test_bad_grant();
        test_reset_mid();
`ifdef AHB_SLAVE_PORT_MUX_ERR_EN
        test_err();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
